// File: rtl/pp_pipeline_accel_mul_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pp_pipeline_accel_mul_arb
// Brief    : Round-robin arbiter/sequencer sharing one pipelined multiplier
//            among NUM_REQ requesters. Tags each product with its requester
//            index and returns it on one result port with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module pp_pipeline_accel_mul_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int DIN0_WIDTH  = 31,
  parameter int DIN1_WIDTH  = 21,
  parameter int DOUT_WIDTH  = 52,
  parameter int MUL_LATENCY = 1
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             mul_ce,
  output logic [DIN0_WIDTH-1:0]            mul_din0,
  output logic [DIN1_WIDTH-1:0]            mul_din1,
  input  logic [DOUT_WIDTH-1:0]            mul_dout,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [ID_WIDTH-1:0]              res_id,
  output logic [DOUT_WIDTH-1:0]            res_dout,
  output logic                             busy
);

  logic                                 advance;
  logic                                 grant_any;
  logic                                 found;
  logic [ID_WIDTH-1:0]                  grant_id;
  int                                   search_idx;

  logic [ID_WIDTH-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [MUL_LATENCY-1:0]               v_q, v_d;
  logic [MUL_LATENCY-1:0][ID_WIDTH-1:0] id_q, id_d;

  // Result side comes straight off the last tag stage; the product is not touched.
  assign res_valid = v_q[MUL_LATENCY-1];
  assign res_id    = id_q[MUL_LATENCY-1];
  assign res_dout  = mul_dout;
  assign busy      = |v_q;

  // Whole pipeline moves together; held off while reset is asserted so that
  // nothing is offered or enabled during reset.
  assign advance = ap_rst_n & (~res_valid | res_ready);
  assign mul_ce  = advance;

  // Round-robin search: first valid requester after the last granted index.
  always_comb begin
    found      = 1'b0;
    grant_id   = '0;
    search_idx = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      search_idx = (int'(rr_ptr_q) + off) % NUM_REQ;
      if (!found && req_valid[search_idx]) begin
        found    = 1'b1;
        grant_id = ID_WIDTH'(search_idx);
      end
    end
    grant_any = found & advance;
  end

  // Handshake decode and operand mux; a bubble drives zero operands.
  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (grant_any) begin
      req_ready[grant_id] = 1'b1;
      mul_din0 = req_din0[grant_id*DIN0_WIDTH +: DIN0_WIDTH];
      mul_din1 = req_din1[grant_id*DIN1_WIDTH +: DIN1_WIDTH];
    end
  end

  // Next state: tag pipeline shifts and pointer updates only on advance.
  always_comb begin
    v_d      = v_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      v_d[0]  = grant_any;
      id_d[0] = grant_id;
      for (int i = 1; i < MUL_LATENCY; i++) begin
        v_d[i]  = v_q[i-1];
        id_d[i] = id_q[i-1];
      end
      if (grant_any) begin
        rr_ptr_d = grant_id;
      end
    end
  end

  // State registers; reset points rr_ptr at the last index so requester 0 wins first.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v_q      <= '0;
      id_q     <= '0;
      rr_ptr_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      v_q      <= v_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pp_pipeline_accel_mul_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pp_pipeline_accel_mul_arb
// Brief    : Self-checking bench for the shared-multiplier arbiter, with an
//            external pipelined multiplier model and a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pp_pipeline_accel_mul_arb;

  localparam int NUM_REQ    = 4;
  localparam int ID_WIDTH   = 2;
  localparam int DIN0_WIDTH = 31;
  localparam int DIN1_WIDTH = 21;
  localparam int DOUT_WIDTH = 52;
  localparam int LAT        = 3;

  logic                          ap_clk = 1'b0;
  logic                          ap_rst_n = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DIN0_WIDTH-1:0] req_din0 = '0;
  logic [NUM_REQ*DIN1_WIDTH-1:0] req_din1 = '0;
  logic                          mul_ce;
  logic [DIN0_WIDTH-1:0]         mul_din0;
  logic [DIN1_WIDTH-1:0]         mul_din1;
  logic [DOUT_WIDTH-1:0]         mul_dout;
  logic                          res_valid;
  logic                          res_ready = 1'b0;
  logic [ID_WIDTH-1:0]           res_id;
  logic [DOUT_WIDTH-1:0]         res_dout;
  logic                          busy;

  pp_pipeline_accel_mul_arb #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH), .DOUT_WIDTH(DOUT_WIDTH), .MUL_LATENCY(LAT)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_dout(res_dout), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  // External multiplier: LAT clock-enabled stages, product at the last one.
  logic [DOUT_WIDTH-1:0] mpipe [LAT];
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      mpipe[0] <= DOUT_WIDTH'(mul_din0) * DOUT_WIDTH'(mul_din1);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  // Reference model: slots of in-flight results (index LAT-1 is the head)
  // plus the index most recently granted.
  bit                    m_v  [LAT];
  int                    m_id [LAT];
  logic [DOUT_WIDTH-1:0] m_p  [LAT];
  int                    last_grant;

  // Requester state held by the bench.
  bit                    rv [NUM_REQ];
  logic [DIN0_WIDTH-1:0] ra [NUM_REQ];
  logic [DIN1_WIDTH-1:0] rb [NUM_REQ];
  bit                    rdy;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = rv[i];
      req_din0[i*DIN0_WIDTH +: DIN0_WIDTH] = ra[i];
      req_din1[i*DIN1_WIDTH +: DIN1_WIDTH] = rb[i];
    end
    res_ready = rdy;
  endtask

  // Raise valid with fresh operands on idle requesters with probability pct.
  task automatic refill(input int pct);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rv[i] && ($urandom_range(99) < pct)) begin
        rv[i] = 1'b1;
        ra[i] = DIN0_WIDTH'($urandom);
        rb[i] = DIN1_WIDTH'($urandom);
      end
    end
  endtask

  // One clock cycle: drive, check against the model, clock, update the model.
  task automatic step(input int exp_rdy);
    bit                 adv;
    bit                 g;
    int                 w;
    int                 idx;
    logic [NUM_REQ-1:0] er;
    bit                 any_v;
    drive();
    #3;
    adv = !m_v[LAT-1] || rdy;
    g   = 1'b0;
    w   = 0;
    if (adv) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (last_grant + k) % NUM_REQ;
        if (!g && rv[idx]) begin
          g = 1'b1;
          w = idx;
        end
      end
    end
    er = '0;
    if (g) er[w] = 1'b1;
    any_v = 1'b0;
    for (int i = 0; i < LAT; i++) any_v |= m_v[i];
    chk("req_ready", req_ready, er);
    chk("mul_ce", mul_ce, adv);
    chk("res_valid", res_valid, m_v[LAT-1]);
    chk("busy", busy, any_v);
    if (m_v[LAT-1]) begin
      chk("res_id", res_id, m_id[LAT-1]);
      chk("res_dout", res_dout, m_p[LAT-1]);
    end
    if (g) begin
      chk("mul_din0", mul_din0, ra[w]);
      chk("mul_din1", mul_din1, rb[w]);
    end else begin
      chk("mul_din0_idle", mul_din0, 0);
      chk("mul_din1_idle", mul_din1, 0);
    end
    if (exp_rdy >= 0) chk("grant_const", req_ready, exp_rdy);
    @(posedge ap_clk);
    if (adv) begin
      for (int i = LAT-1; i > 0; i--) begin
        m_v[i]  = m_v[i-1];
        m_id[i] = m_id[i-1];
        m_p[i]  = m_p[i-1];
      end
      m_v[0]  = g;
      m_id[0] = w;
      m_p[0]  = g ? DOUT_WIDTH'(ra[w]) * DOUT_WIDTH'(rb[w]) : '0;
      if (g) begin
        last_grant = w;
        rv[w]      = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_ce", mul_ce, 0);
    for (int i = 0; i < LAT; i++) begin
      m_v[i]  = 1'b0;
      m_id[i] = 0;
      m_p[i]  = '0;
    end
    last_grant = NUM_REQ - 1;
    @(posedge ap_clk);
    #1;
    chk("rst_hold_valid", res_valid, 0);
    chk("rst_hold_ready", req_ready, 0);
    ap_rst_n = 1'b1;
  endtask

  initial begin
    int waited;
    rdy = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rv[i] = 1'b1;
      ra[i] = '0;
      rb[i] = '0;
    end
    drive();
    #1;
    // Reset with every requester asking: ready must stay forced low.
    do_reset();

    // Single request from requester 2.
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b0;
    rv[2] = 1'b1; ra[2] = 31'd1000; rb[2] = 21'd3;
    step(4'b0100);
    for (int i = 1; i < LAT; i++) step(-1);
    chk("single_valid", res_valid, 1);
    chk("single_id", res_id, 2);
    chk("single_dout", res_dout, 52'd3000);
    step(-1);

    // Full contention from reset: strict 0,1,2,3 rotation.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      refill(100);
      step(1 << (k % NUM_REQ));
    end

    // Backpressure for 5 cycles with a full pipeline, then release.
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      refill(100);
      step(0);
    end
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      refill(100);
      step(-1);
    end

    // Maximum and zero operands.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b0;
    rv[0] = 1'b1; ra[0] = 31'h7FFF_FFFF; rb[0] = 21'h1F_FFFF;
    rv[1] = 1'b1; ra[1] = 31'd0;         rb[1] = 21'h1F_FFFF;
    step(4'b0001);
    step(4'b0010);
    for (int i = 2; i < LAT; i++) step(-1);
    chk("max_dout", res_dout, 52'hF_FFFF_7FE0_0001);
    step(-1);
    chk("zero_dout", res_dout, 52'd0);
    for (int i = 0; i < LAT; i++) step(-1);

    // Fairness: requester 1 always valid, requester 3 raises once.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b0;
    rv[1] = 1'b1;
    step(4'b0010);
    rv[1] = 1'b1;
    rv[3] = 1'b1; ra[3] = 31'd77; rb[3] = 21'd5;
    waited = 0;
    for (int k = 0; k < 4; k++) begin
      if (rv[3]) begin
        waited++;
        rv[1] = 1'b1;
        step(-1);
      end
    end
    chk("fair_wait", (waited <= 2), 1);
    for (int k = 0; k < 6; k++) begin
      rv[1] = 1'b1;
      step(-1);
    end
    rv[1] = 1'b0;
    for (int i = 0; i < LAT; i++) step(-1);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      refill(50);
      rdy = ($urandom_range(99) < 70);
      step(-1);
    end

    // Reset in the middle of a full pipeline: no stale results afterwards.
    rdy = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      refill(100);
      step(-1);
    end
    chk("pre_reset_busy", busy, 1);
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rv[i] = 1'b1;
    step(4'b0001);
    for (int k = 0; k < LAT + 4; k++) begin
      refill(100);
      step(-1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
